// File: rtl/dht11_pkg.sv
// Shared types and constants for the DHT11 read scheduler and its BCD converter.
package dht11_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_DONE,
        ST_WAIT_PERIOD,
        ST_CONVERT
    } state_e;

    localparam int unsigned CLK_HZ_DEFAULT = 100_000_000;
    localparam int unsigned MS_TICKS       = CLK_HZ_DEFAULT / 1000;
    localparam int unsigned BCD_ITER       = 8;

    // Integral byte position inside the controller's {integral, decimal} words.
    localparam int unsigned INT_BYTE_MSB = 15;
    localparam int unsigned INT_BYTE_LSB = 8;

    function automatic int unsigned ms_ticks(input int unsigned clk_hz);
        return (clk_hz >= 1000) ? clk_hz / 1000 : 1;
    endfunction

endpackage

// File: rtl/dht11_sampler_bin2bcd.sv
// bin2bcd_seq: 8-bit sequential double-dabble, one shift/add-3 step per cycle,
// registered 12-bit result and a one-cycle done pulse.
module bin2bcd_seq
    import dht11_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [7:0]  bin_i,
    output logic        done_o,
    output logic [11:0] bcd_o
);

    localparam int unsigned IW = $clog2(BCD_ITER);

    logic [19:0]   shift_q, shift_d, adj;
    logic [IW-1:0] iter_q, iter_d;
    logic          active_q, active_d;
    logic          done_q, done_d;
    logic [11:0]   bcd_q, bcd_d;

    always_comb begin
        adj = shift_q;
        for (int i = 0; i < 3; i++) begin
            if (shift_q[8+4*i +: 4] >= 4'd5) begin
                adj[8+4*i +: 4] = shift_q[8+4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can infer a latch.
        shift_d  = shift_q;
        iter_d   = iter_q;
        active_d = active_q;
        done_d   = 1'b0;
        bcd_d    = bcd_q;
        if (active_q) begin
            shift_d = {adj[18:0], 1'b0};
            iter_d  = iter_q + 1'b1;
            if (iter_q == IW'(BCD_ITER - 1)) begin
                active_d = 1'b0;
                done_d   = 1'b1;
                bcd_d    = adj[18:7];
            end
        end else if (start_i) begin
            shift_d  = {12'd0, bin_i};
            iter_d   = '0;
            active_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all updates land together on the edge.
        if (rst) begin
            shift_q  <= '0;
            iter_q   <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            bcd_q    <= '0;
        end else begin
            shift_q  <= shift_d;
            iter_q   <= iter_d;
            active_q <= active_d;
            done_q   <= done_d;
            bcd_q    <= bcd_d;
        end
    end

    assign done_o = done_q;
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/dht11_sampler.sv
// Periodic DHT11 read scheduler: triggers the controller, captures valid results and
// converts the selected integral byte to BCD. Define DHT11_ERRCNT_EN to add err_cnt.
module dht11_sampler
    import dht11_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned PERIOD_MS  = 2000,
    parameter int unsigned TIMEOUT_MS = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        sel_temp,
    input  logic        dht11_done,
    input  logic        dht11_valid,
    input  logic [15:0] humidity,
    input  logic [15:0] temperature,
    output logic        dht11_start,
    output logic [7:0]  hum_int,
    output logic [7:0]  temp_int,
    output logic [11:0] bcd,
    output logic        bcd_valid,
    output logic        data_fresh,
    output logic        busy
`ifdef DHT11_ERRCNT_EN
    ,
    output logic [7:0]  err_cnt
`endif
);

    localparam int unsigned TICKS   = ms_ticks(CLK_HZ);
    localparam int unsigned PRESC_W = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam int unsigned MS_MAX  = (PERIOD_MS > TIMEOUT_MS) ? PERIOD_MS : TIMEOUT_MS;
    localparam int unsigned MS_W    = $clog2(MS_MAX + 1);

    state_e             state_q, state_d;
    state_e             ret_q, ret_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [MS_W-1:0]    ms_q, ms_d;
    logic [MS_W:0]      ms_sum;
    logic [7:0]         hum_q, hum_d, temp_q, temp_d;
    logic               fresh_q, fresh_d;
    logic               pending_q, pending_d;
    logic               sel_prev_q;
    logic               conv_start_q, conv_start_d;
    logic               tick, counting, period_done, timeout, toggle, fail;
    logic [7:0]         conv_bin;

    assign tick        = (presc_q == PRESC_W'(TICKS - 1));
    assign ms_sum      = {1'b0, ms_q} + {{MS_W{1'b0}}, tick};
    assign period_done = (ms_sum >= (MS_W+1)'(PERIOD_MS));
    assign timeout     = (ms_sum >= (MS_W+1)'(TIMEOUT_MS));
    assign toggle      = sel_temp ^ sel_prev_q;
    // Timing runs from START onward; a display-only conversion out of IDLE leaves it at zero.
    assign counting    = (state_q != ST_IDLE) && !(state_q == ST_CONVERT && ret_q == ST_IDLE);

    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        hum_d        = hum_q;
        temp_d       = temp_q;
        fresh_d      = fresh_q;
        conv_start_d = 1'b0;
        fail         = 1'b0;
        presc_d      = presc_q;
        ms_d         = ms_q;

        if (counting) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick && ms_q != MS_W'(MS_MAX)) ms_d = ms_q + 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                presc_d = '0;
                ms_d    = '0;
                if (pending_q) begin
                    state_d      = ST_CONVERT;
                    ret_d        = ST_IDLE;
                    conv_start_d = 1'b1;
                end else if (enable) begin
                    state_d = ST_START;
                end
            end
            ST_START: state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (dht11_done && dht11_valid) begin
                    hum_d        = humidity[INT_BYTE_MSB:INT_BYTE_LSB];
                    temp_d       = temperature[INT_BYTE_MSB:INT_BYTE_LSB];
                    fresh_d      = 1'b1;
                    state_d      = ST_CONVERT;
                    ret_d        = ST_WAIT_PERIOD;
                    conv_start_d = 1'b1;
                end else if (dht11_done || timeout) begin
                    fail    = 1'b1;
                    state_d = ST_WAIT_PERIOD;
                end
            end
            ST_WAIT_PERIOD: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (pending_q) begin
                    state_d      = ST_CONVERT;
                    ret_d        = ST_WAIT_PERIOD;
                    conv_start_d = 1'b1;
                end else if (period_done) begin
                    state_d = ST_START;
                end
            end
            ST_CONVERT: begin
                if (bcd_valid) begin
                    if (pending_q)    conv_start_d = 1'b1;
                    else if (!enable) state_d      = ST_IDLE;
                    else              state_d      = ret_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (fail) fresh_d = 1'b0;
        if (state_d == ST_START) begin
            presc_d = '0;
            ms_d    = '0;
        end
    end

    // A toggle seen in the cycle a conversion loads is already covered by that conversion.
    assign pending_d = !conv_start_q && (pending_q || toggle);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ret_q        <= ST_IDLE;
            presc_q      <= '0;
            ms_q         <= '0;
            hum_q        <= '0;
            temp_q       <= '0;
            fresh_q      <= 1'b0;
            pending_q    <= 1'b0;
            sel_prev_q   <= sel_temp;
            conv_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            presc_q      <= presc_d;
            ms_q         <= ms_d;
            hum_q        <= hum_d;
            temp_q       <= temp_d;
            fresh_q      <= fresh_d;
            pending_q    <= pending_d;
            sel_prev_q   <= sel_temp;
            conv_start_q <= conv_start_d;
        end
    end

`ifdef DHT11_ERRCNT_EN
    logic [7:0] err_q;

    always_ff @(posedge clk) begin
        if (rst)                        err_q <= '0;
        else if (fail && err_q != 8'hFF) err_q <= err_q + 1'b1;
    end

    assign err_cnt = err_q;
`endif

    assign conv_bin = sel_temp ? temp_q : hum_q;

    bin2bcd_seq u_bin2bcd (
        .clk     (clk),
        .rst     (rst),
        .start_i (conv_start_q),
        .bin_i   (conv_bin),
        .done_o  (bcd_valid),
        .bcd_o   (bcd)
    );

    assign dht11_start = (state_q == ST_START);
    assign busy        = (state_q == ST_START) || (state_q == ST_WAIT_DONE);
    assign hum_int     = hum_q;
    assign temp_int    = temp_q;
    assign data_fresh  = fresh_q;

endmodule
